// File: rtl/lives_controller.sv
// Player-life bookkeeping: tracks the life count through hits, bonuses and frame-timed
// immunity, and drives the thermometer lives mask plus game-state flags.
module lives_controller #(
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_BIT     = 3
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 startGame,
  input  logic                 hit,
  input  logic                 extraLife,
  output logic [MAX_LIVES-1:0] lives,
  output logic                 gameOver,
  output logic                 invulnerable,
  output logic                 blinkHide
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    INVULN    = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam logic [2:0] MAX_CNT     = 3'(MAX_LIVES);
  localparam logic [9:0] INVULN_LOAD = 10'(INVULN_FRAMES);

  state_t               state_r;
  state_t               state_s;
  logic [2:0]           count_r;
  logic [2:0]           count_s;
  logic [9:0]           frame_cnt_r;
  logic [9:0]           frame_cnt_s;
  logic [MAX_LIVES-1:0] lives_s;

  function automatic logic [2:0] sat_inc(input logic [2:0] c);
    if (c < MAX_CNT) begin
      return c + 3'd1;
    end else begin
      return c;
    end
  endfunction

  // Next state, life count and immunity frame counter.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    frame_cnt_s = frame_cnt_r;
    case (state_r)
      IDLE, GAME_OVER: begin
        if (startGame) begin
          state_s = PLAY;
          count_s = MAX_CNT;
        end else begin
          state_s = state_r;
        end
      end
      PLAY: begin
        // A bonus in the same clk as a hit cancels the loss but immunity is still granted.
        if (hit && extraLife) begin
          state_s     = INVULN;
          frame_cnt_s = INVULN_LOAD;
        end else if (hit && (count_r <= 3'd1)) begin
          state_s     = GAME_OVER;
          count_s     = 3'd0;
          frame_cnt_s = 10'd0;
        end else if (hit) begin
          state_s     = INVULN;
          count_s     = count_r - 3'd1;
          frame_cnt_s = INVULN_LOAD;
        end else if (extraLife) begin
          count_s = sat_inc(count_r);
        end else begin
          count_s = count_r;
        end
      end
      INVULN: begin
        if (extraLife) begin
          count_s = sat_inc(count_r);
        end else begin
          count_s = count_r;
        end
        if (startOfFrame) begin
          if (frame_cnt_r <= 10'd1) begin
            state_s     = PLAY;
            frame_cnt_s = 10'd0;
          end else begin
            frame_cnt_s = frame_cnt_r - 10'd1;
          end
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      default: begin
        state_s     = IDLE;
        count_s     = 3'd0;
        frame_cnt_s = 10'd0;
      end
    endcase
  end

  // Thermometer mask from the next count so the registered mask tracks count without lag.
  always_comb begin
    lives_s = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      lives_s[i] = (count_s > 3'(i));
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= IDLE;
      count_r      <= 3'd0;
      frame_cnt_r  <= 10'd0;
      lives        <= '0;
      gameOver     <= 1'b0;
      invulnerable <= 1'b0;
      blinkHide    <= 1'b0;
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      frame_cnt_r  <= frame_cnt_s;
      lives        <= lives_s;
      gameOver     <= (state_s == GAME_OVER);
      invulnerable <= (state_s == INVULN);
      blinkHide    <= (state_s == INVULN) & frame_cnt_s[BLINK_BIT];
    end
  end

endmodule

// File: tb/tb_lives_controller.sv
// Scoreboard bench for lives_controller: a driver pushes reference-model expectations,
// a monitor pops and compares them one clk later.
module tb_lives_controller;

  localparam int MAXL = 3;
  localparam int INV  = 120;
  localparam int BB   = 3;

  logic            clk = 1'b0;
  logic            resetN = 1'b0;
  logic            startOfFrame = 1'b0;
  logic            startGame = 1'b0;
  logic            hit = 1'b0;
  logic            extraLife = 1'b0;
  logic [MAXL-1:0] lives;
  logic            gameOver;
  logic            invulnerable;
  logic            blinkHide;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [MAXL+2:0] exp_q[$];

  // reference model: 0 idle, 1 play, 2 immune, 3 game over
  int m_mode = 0;
  int m_n    = 0;
  int m_left = 0;

  lives_controller #(.MAX_LIVES(MAXL), .INVULN_FRAMES(INV), .BLINK_BIT(BB)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .hit(hit), .extraLife(extraLife), .lives(lives), .gameOver(gameOver),
    .invulnerable(invulnerable), .blinkHide(blinkHide)
  );

  always #5 clk = ~clk;

  function automatic logic [MAXL+2:0] model_out();
    int mask;
    logic [MAXL-1:0] m;
    logic blink;
    mask  = (1 << m_n) - 1;
    m     = mask[MAXL-1:0];
    blink = (m_mode == 2) && (((m_left >> BB) & 1) == 1);
    return {m, (m_mode == 3), (m_mode == 2), blink};
  endfunction

  task automatic model_step(input logic s, input logic g, input logic h, input logic x);
    if (m_mode == 0 || m_mode == 3) begin
      if (g) begin m_mode = 1; m_n = MAXL; end
    end else if (m_mode == 1) begin
      if (h && x) begin
        m_mode = 2; m_left = INV;
      end else if (h && m_n == 1) begin
        m_mode = 3; m_n = 0;
      end else if (h) begin
        m_mode = 2; m_n = m_n - 1; m_left = INV;
      end else if (x) begin
        m_n = (m_n + 1 > MAXL) ? MAXL : m_n + 1;
      end
    end else begin
      if (x) m_n = (m_n + 1 > MAXL) ? MAXL : m_n + 1;
      if (s) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 1;
      end
    end
  endtask

  task automatic step(input logic s, input logic g, input logic h, input logic x);
    @(negedge clk);
    startOfFrame = s; startGame = g; hit = h; extraLife = x;
    model_step(s, g, h, x);
    exp_q.push_back(model_out());
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 1'b0; startGame = 1'b0; hit = 1'b0; extraLife = 1'b0;
    #1;
    check("async_reset_outputs", int'({lives, gameOver, invulnerable, blinkHide}), 0);
    m_mode = 0; m_n = 0; m_left = 0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation just after each edge.
  initial begin
    logic [MAXL+2:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({lives, gameOver, invulnerable, blinkHide} !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got={lives,go,inv,blink}=%b expected=%b",
                   cyc, {lives, gameOver, invulnerable, blinkHide}, e);
        end
      end
    end
  end

  initial begin
    int burst;
    logic s, g, h, x;
    do_reset();
    // idle: hits and bonuses ignored
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    // start, repeated start ignored
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    // hit held 5 clks costs one life, then full immunity with blink
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    idle_frames(INV);
    // two more hits to game over, then restart
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_frames(INV + 2);
    // bonus at one life, then back down
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_frames(INV + 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    // saturated bonus, then hit+bonus at two lives
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle_frames(INV);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    // reset mid-immunity with frameCnt at 50
    idle_frames(INV - 50);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    // randomized traffic
    burst = 0;
    for (int i = 0; i < 15000; i++) begin
      if (i % 4000 == 3999) begin
        do_reset();
      end
      s = ($urandom_range(0, 2) == 0);
      if (burst > 0) begin
        h = 1'b1; burst--;
      end else begin
        h = 1'b0;
        if ($urandom_range(0, 39) == 0) burst = $urandom_range(1, 6);
      end
      x = ($urandom_range(0, 24) == 0);
      g = ($urandom_range(0, 59) == 0);
      step(s, g, h, x);
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
